// File: rtl/regfile_ctrl_pkg.sv
// Shared types, constants and output decode for the regfile_ctrl sequencer.
// The optional skid buffer (REGFILE_CTRL_SKID_EN) reuses cmd_t from here.
package regfile_ctrl_pkg;

    localparam int SEL_W = 3;
    localparam logic [SEL_W-1:0] TMP_REG = 3'd7;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_MOV  = 3'd1,
        OP_ALU  = 3'd2,
        OP_SWAP = 3'd3,
        OP_AMOV = 3'd4,
        OP_AINC = 3'd5
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EX1  = 2'd1,
        ST_EX2  = 2'd2,
        ST_EX3  = 2'd3
    } state_t;

    typedef struct packed {
        op_t              op;
        logic [SEL_W-1:0] dst;
        logic [SEL_W-1:0] src;
        logic [SEL_W-1:0] src2;
    } cmd_t;

    typedef struct packed {
        logic             main_assert_bar;
        logic             main_load_bar;
        logic             lhs_assert_bar;
        logic             rhs_assert_bar;
        logic             addr_assert_bar;
        logic             addr_load_bar;
        logic             addr_inc;
        logic             alu_assert_bar;
        logic             busy;
        logic             done;
        logic             err;
        logic [SEL_W-1:0] main_assert_sel;
        logic [SEL_W-1:0] main_load_sel;
        logic [SEL_W-1:0] lhs_assert_sel;
        logic [SEL_W-1:0] rhs_assert_sel;
        logic [SEL_W-1:0] addr_assert_sel;
        logic [SEL_W-1:0] addr_load_sel;
        logic [SEL_W-1:0] addr_inc_sel;
    } ctrl_out_t;

    function automatic ctrl_out_t idle_out();
        ctrl_out_t o;
        o = '0;
        o.main_assert_bar = 1'b1;
        o.main_load_bar   = 1'b1;
        o.lhs_assert_bar  = 1'b1;
        o.rhs_assert_bar  = 1'b1;
        o.addr_assert_bar = 1'b1;
        o.addr_load_bar   = 1'b1;
        o.alu_assert_bar  = 1'b1;
        return o;
    endfunction

    function automatic logic cmd_illegal(cmd_t c);
        return (c.op > OP_AINC) ||
               ((c.op == OP_SWAP) && ((c.src == TMP_REG) || (c.dst == TMP_REG)));
    endfunction

    // Illegal commands collapse to a single NOP-like cycle.
    function automatic state_t last_state(cmd_t c);
        if (cmd_illegal(c))       return ST_EX1;
        else if (c.op == OP_ALU)  return ST_EX2;
        else if (c.op == OP_SWAP) return ST_EX3;
        else                      return ST_EX1;
    endfunction

    function automatic ctrl_out_t with_mov(ctrl_out_t o_in, logic [SEL_W-1:0] from,
                                           logic [SEL_W-1:0] to);
        ctrl_out_t o;
        o = o_in;
        o.main_assert_bar = 1'b0;
        o.main_assert_sel = from;
        o.main_load_bar   = 1'b0;
        o.main_load_sel   = to;
        return o;
    endfunction

    function automatic ctrl_out_t decode_out(state_t st, cmd_t c);
        ctrl_out_t o;
        o = idle_out();
        if (st != ST_IDLE) begin
            o.busy = 1'b1;
            o.done = (st == last_state(c));
            if (cmd_illegal(c)) begin
                o.err = 1'b1;
            end else begin
                case (c.op)
                    OP_MOV: o = with_mov(o, c.src, c.dst);
                    OP_ALU: begin
                        o.lhs_assert_bar = 1'b0;
                        o.lhs_assert_sel = c.src;
                        o.rhs_assert_bar = 1'b0;
                        o.rhs_assert_sel = c.src2;
                        if (st == ST_EX2) begin
                            o.alu_assert_bar = 1'b0;
                            o.main_load_bar  = 1'b0;
                            o.main_load_sel  = c.dst;
                        end
                    end
                    OP_SWAP: begin
                        case (st)
                            ST_EX1:  o = with_mov(o, c.src, TMP_REG);
                            ST_EX2:  o = with_mov(o, c.dst, c.src);
                            default: o = with_mov(o, TMP_REG, c.dst);
                        endcase
                    end
                    OP_AMOV: begin
                        o.addr_assert_bar = 1'b0;
                        o.addr_assert_sel = c.src;
                        o.addr_load_bar   = 1'b0;
                        o.addr_load_sel   = c.dst;
                    end
                    OP_AINC: begin
                        o.addr_inc     = 1'b1;
                        o.addr_inc_sel = c.dst;
                    end
                    default: ;
                endcase
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/regfile_ctrl_cmdbuf.sv
// One-entry command holding register used by regfile_ctrl when
// REGFILE_CTRL_SKID_EN is defined; lets a command be accepted while busy.
module regfile_ctrl_cmdbuf
    import regfile_ctrl_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_push,
    input  cmd_t i_cmd,
    input  logic i_pop,
    output logic o_full,
    output cmd_t o_cmd
);

    logic r_full;
    cmd_t r_cmd;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_full <= 1'b0;
            r_cmd  <= '0;
        end else if (i_push) begin
            r_full <= 1'b1;
            r_cmd  <= i_cmd;
        end else if (i_pop) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_cmd  = r_cmd;

endmodule

// File: rtl/regfile_ctrl.sv
// Register-transfer sequencer: expands one command into 1-3 cycles of registerfile strobes.
// Define REGFILE_CTRL_SKID_EN to add a one-entry buffer for back-to-back commands.
module regfile_ctrl
    import regfile_ctrl_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [2:0]       CMD_OP,
    input  logic [SEL_W-1:0] CMD_DST,
    input  logic [SEL_W-1:0] CMD_SRC,
    input  logic [SEL_W-1:0] CMD_SRC2,
    output logic             BUSY,
    output logic             DONE,
    output logic             CMD_ERR,
    output logic             MAIN_ASSERT_bar,
    output logic             MAIN_LOAD_bar,
    output logic             LHS_ASSERT_bar,
    output logic             RHS_ASSERT_bar,
    output logic             ADDR_ASSERT_bar,
    output logic             ADDR_LOAD_bar,
    output logic             ADDR_INC,
    output logic             ALU_ASSERT_bar,
    output logic [SEL_W-1:0] MAIN_ASSERT_SEL,
    output logic [SEL_W-1:0] MAIN_LOAD_SEL,
    output logic [SEL_W-1:0] LHS_ASSERT_SEL,
    output logic [SEL_W-1:0] RHS_ASSERT_SEL,
    output logic [SEL_W-1:0] ADDR_ASSERT_SEL,
    output logic [SEL_W-1:0] ADDR_LOAD_SEL,
    output logic [SEL_W-1:0] ADDR_INC_SEL
);

    state_t    r_state;
    cmd_t      r_cmd;
    ctrl_out_t r_out;

    state_t    w_state_nx;
    cmd_t      w_cmd_nx;
    cmd_t      w_in_cmd;
    logic      w_ready;
    logic      w_accept;
    logic      w_last;

    assign w_in_cmd = '{op: op_t'(CMD_OP), dst: CMD_DST, src: CMD_SRC, src2: CMD_SRC2};
    assign w_accept = CMD_VALID && w_ready;
    assign w_last   = (r_state == last_state(r_cmd));

`ifdef REGFILE_CTRL_SKID_EN
    logic w_buf_full;
    logic w_buf_push;
    logic w_buf_pop;
    cmd_t w_buf_cmd;

    regfile_ctrl_cmdbuf u_cmdbuf (
        .i_clk  (CLK),
        .i_rst  (RST),
        .i_push (w_buf_push),
        .i_cmd  (w_in_cmd),
        .i_pop  (w_buf_pop),
        .o_full (w_buf_full),
        .o_cmd  (w_buf_cmd)
    );

    assign w_ready = !w_buf_full;
`else
    assign w_ready = (r_state == ST_IDLE);
`endif

    always_comb begin
        w_state_nx = r_state;
        w_cmd_nx   = r_cmd;
`ifdef REGFILE_CTRL_SKID_EN
        w_buf_push = 1'b0;
        w_buf_pop  = 1'b0;
`endif
        if (r_state == ST_IDLE) begin
            if (w_accept) begin
                w_state_nx = ST_EX1;
                w_cmd_nx   = w_in_cmd;
            end
        end else if (!w_last) begin
            w_state_nx = (r_state == ST_EX1) ? ST_EX2 : ST_EX3;
`ifdef REGFILE_CTRL_SKID_EN
            w_buf_push = w_accept;
`endif
        end else begin
`ifdef REGFILE_CTRL_SKID_EN
            // Buffered command has priority; a direct accept only happens when it is empty.
            if (w_buf_full) begin
                w_state_nx = ST_EX1;
                w_cmd_nx   = w_buf_cmd;
                w_buf_pop  = 1'b1;
            end else if (w_accept) begin
                w_state_nx = ST_EX1;
                w_cmd_nx   = w_in_cmd;
            end else begin
                w_state_nx = ST_IDLE;
            end
`else
            w_state_nx = ST_IDLE;
`endif
        end
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_cmd   <= '0;
            r_out   <= idle_out();
        end else begin
            r_state <= w_state_nx;
            r_cmd   <= w_cmd_nx;
            r_out   <= decode_out(w_state_nx, w_cmd_nx);
        end
    end

    assign CMD_READY       = w_ready;
    assign BUSY            = r_out.busy;
    assign DONE            = r_out.done;
    assign CMD_ERR         = r_out.err;
    assign MAIN_ASSERT_bar = r_out.main_assert_bar;
    assign MAIN_LOAD_bar   = r_out.main_load_bar;
    assign LHS_ASSERT_bar  = r_out.lhs_assert_bar;
    assign RHS_ASSERT_bar  = r_out.rhs_assert_bar;
    assign ADDR_ASSERT_bar = r_out.addr_assert_bar;
    assign ADDR_LOAD_bar   = r_out.addr_load_bar;
    assign ADDR_INC        = r_out.addr_inc;
    assign ALU_ASSERT_bar  = r_out.alu_assert_bar;
    assign MAIN_ASSERT_SEL = r_out.main_assert_sel;
    assign MAIN_LOAD_SEL   = r_out.main_load_sel;
    assign LHS_ASSERT_SEL  = r_out.lhs_assert_sel;
    assign RHS_ASSERT_SEL  = r_out.rhs_assert_sel;
    assign ADDR_ASSERT_SEL = r_out.addr_assert_sel;
    assign ADDR_LOAD_SEL   = r_out.addr_load_sel;
    assign ADDR_INC_SEL    = r_out.addr_inc_sel;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed self-checking bench for regfile_ctrl; inputs change and outputs are sampled on the falling edge.
module tb_regfile_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic [2:0] CMD_OP, CMD_DST, CMD_SRC, CMD_SRC2;
    logic       BUSY, DONE, CMD_ERR;
    logic       MAIN_ASSERT_bar, MAIN_LOAD_bar, LHS_ASSERT_bar, RHS_ASSERT_bar;
    logic       ADDR_ASSERT_bar, ADDR_LOAD_bar, ADDR_INC, ALU_ASSERT_bar;
    logic [2:0] MAIN_ASSERT_SEL, MAIN_LOAD_SEL, LHS_ASSERT_SEL, RHS_ASSERT_SEL;
    logic [2:0] ADDR_ASSERT_SEL, ADDR_LOAD_SEL, ADDR_INC_SEL;

    int total = 0;
    int bad   = 0;

    // strobe vector: {MA,ML,LHS,RHS,AA,AL}_bar, ADDR_INC, ALU_bar, BUSY, DONE, CMD_ERR
    localparam logic [10:0] S_IDLE     = 11'b111111_0_1_0_0_0;
    localparam logic [10:0] S_MOV_MID  = 11'b001111_0_1_1_0_0;
    localparam logic [10:0] S_MOV_DONE = 11'b001111_0_1_1_1_0;
    localparam logic [10:0] S_ALU1     = 11'b110011_0_1_1_0_0;
    localparam logic [10:0] S_ALU2     = 11'b100011_0_0_1_1_0;
    localparam logic [10:0] S_ERR      = 11'b111111_0_1_1_1_1;
    localparam logic [10:0] S_NOP      = 11'b111111_0_1_1_1_0;
    localparam logic [10:0] S_AINC     = 11'b111111_1_1_1_1_0;
    localparam logic [10:0] S_AMOV     = 11'b111100_0_1_1_1_0;

    regfile_ctrl dut (
        .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_OP(CMD_OP), .CMD_DST(CMD_DST), .CMD_SRC(CMD_SRC), .CMD_SRC2(CMD_SRC2),
        .BUSY(BUSY), .DONE(DONE), .CMD_ERR(CMD_ERR),
        .MAIN_ASSERT_bar(MAIN_ASSERT_bar), .MAIN_LOAD_bar(MAIN_LOAD_bar),
        .LHS_ASSERT_bar(LHS_ASSERT_bar), .RHS_ASSERT_bar(RHS_ASSERT_bar),
        .ADDR_ASSERT_bar(ADDR_ASSERT_bar), .ADDR_LOAD_bar(ADDR_LOAD_bar),
        .ADDR_INC(ADDR_INC), .ALU_ASSERT_bar(ALU_ASSERT_bar),
        .MAIN_ASSERT_SEL(MAIN_ASSERT_SEL), .MAIN_LOAD_SEL(MAIN_LOAD_SEL),
        .LHS_ASSERT_SEL(LHS_ASSERT_SEL), .RHS_ASSERT_SEL(RHS_ASSERT_SEL),
        .ADDR_ASSERT_SEL(ADDR_ASSERT_SEL), .ADDR_LOAD_SEL(ADDR_LOAD_SEL),
        .ADDR_INC_SEL(ADDR_INC_SEL)
    );

    // clock / reset block
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [10:0] strb();
        return {MAIN_ASSERT_bar, MAIN_LOAD_bar, LHS_ASSERT_bar, RHS_ASSERT_bar,
                ADDR_ASSERT_bar, ADDR_LOAD_bar, ADDR_INC, ALU_ASSERT_bar, BUSY, DONE, CMD_ERR};
    endfunction

    // select vector: {MA, ML, LHS, RHS, AA, AL, INC}
    function automatic logic [20:0] sels();
        return {MAIN_ASSERT_SEL, MAIN_LOAD_SEL, LHS_ASSERT_SEL, RHS_ASSERT_SEL,
                ADDR_ASSERT_SEL, ADDR_LOAD_SEL, ADDR_INC_SEL};
    endfunction

    // driver: waits (bounded) for READY, holds the command for one edge, then scrambles fields
    task automatic send_cmd(input logic [2:0] op, input logic [2:0] dst,
                            input logic [2:0] src, input logic [2:0] src2);
        int n;
        n = 0;
        @(negedge CLK);
        while (!CMD_READY && n < 20) begin
            @(negedge CLK);
            n++;
        end
        total++;
        if (CMD_READY !== 1'b1) begin
            bad++;
            $display("FAIL ready_wait got=%b exp=1", CMD_READY);
        end
        CMD_VALID = 1'b1; CMD_OP = op; CMD_DST = dst; CMD_SRC = src; CMD_SRC2 = src2;
        @(negedge CLK);
        CMD_VALID = 1'b0;
        CMD_OP   = 3'($urandom_range(0, 7));
        CMD_DST  = 3'($urandom_range(0, 7));
        CMD_SRC  = 3'($urandom_range(0, 7));
        CMD_SRC2 = 3'($urandom_range(0, 7));
    endtask

    task automatic test_reset();
        RST = 1'b1; CMD_VALID = 1'b0;
        CMD_OP = 3'd0; CMD_DST = 3'd0; CMD_SRC = 3'd0; CMD_SRC2 = 3'd0;
        #12;
        total++; if (strb() !== S_IDLE) begin bad++; $display("FAIL reset_strb got=%b exp=%b", strb(), S_IDLE); end
        total++; if (sels() !== 21'd0) begin bad++; $display("FAIL reset_sels got=%h exp=0", sels()); end
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        total++; if (CMD_READY !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", CMD_READY); end
        total++; if (strb() !== S_IDLE) begin bad++; $display("FAIL reset_idle got=%b exp=%b", strb(), S_IDLE); end
    endtask

    task automatic test_mov();
        send_cmd(3'd1, 3'd5, 3'd2, 3'd0);
        total++; if (strb() !== S_MOV_DONE) begin bad++; $display("FAIL mov_strb got=%b exp=%b", strb(), S_MOV_DONE); end
        total++; if (sels() !== {3'd2, 3'd5, 15'd0}) begin bad++; $display("FAIL mov_sels got=%h exp=%h", sels(), {3'd2, 3'd5, 15'd0}); end
`ifndef REGFILE_CTRL_SKID_EN
        total++; if (CMD_READY !== 1'b0) begin bad++; $display("FAIL mov_ready_busy got=%b exp=0", CMD_READY); end
`endif
        @(negedge CLK);
        total++; if (strb() !== S_IDLE) begin bad++; $display("FAIL mov_after got=%b exp=%b", strb(), S_IDLE); end
        total++; if (CMD_READY !== 1'b1) begin bad++; $display("FAIL mov_ready_back got=%b exp=1", CMD_READY); end
    endtask

    task automatic test_alu();
        send_cmd(3'd2, 3'd4, 3'd1, 3'd3);
        total++; if (strb() !== S_ALU1) begin bad++; $display("FAIL alu_ex1_strb got=%b exp=%b", strb(), S_ALU1); end
        total++; if (sels() !== {6'd0, 3'd1, 3'd3, 9'd0}) begin bad++; $display("FAIL alu_ex1_sels got=%h exp=%h", sels(), {6'd0, 3'd1, 3'd3, 9'd0}); end
        @(negedge CLK);
        total++; if (strb() !== S_ALU2) begin bad++; $display("FAIL alu_ex2_strb got=%b exp=%b", strb(), S_ALU2); end
        total++; if (sels() !== {3'd0, 3'd4, 3'd1, 3'd3, 9'd0}) begin bad++; $display("FAIL alu_ex2_sels got=%h exp=%h", sels(), {3'd0, 3'd4, 3'd1, 3'd3, 9'd0}); end
        @(negedge CLK);
        total++; if (strb() !== S_IDLE) begin bad++; $display("FAIL alu_after got=%b exp=%b", strb(), S_IDLE); end
    endtask

    task automatic test_swap();
        send_cmd(3'd3, 3'd1, 3'd0, 3'd0);
        total++; if (strb() !== S_MOV_MID) begin bad++; $display("FAIL swap_ex1_strb got=%b exp=%b", strb(), S_MOV_MID); end
        total++; if (sels() !== {3'd0, 3'd7, 15'd0}) begin bad++; $display("FAIL swap_ex1_sels got=%h exp=%h", sels(), {3'd0, 3'd7, 15'd0}); end
        @(negedge CLK);
        total++; if (strb() !== S_MOV_MID) begin bad++; $display("FAIL swap_ex2_strb got=%b exp=%b", strb(), S_MOV_MID); end
        total++; if (sels() !== {3'd1, 3'd0, 15'd0}) begin bad++; $display("FAIL swap_ex2_sels got=%h exp=%h", sels(), {3'd1, 3'd0, 15'd0}); end
        @(negedge CLK);
        total++; if (strb() !== S_MOV_DONE) begin bad++; $display("FAIL swap_ex3_strb got=%b exp=%b", strb(), S_MOV_DONE); end
        total++; if (sels() !== {3'd7, 3'd1, 15'd0}) begin bad++; $display("FAIL swap_ex3_sels got=%h exp=%h", sels(), {3'd7, 3'd1, 15'd0}); end
        // SRC==DST is legal and still takes three cycles
        send_cmd(3'd3, 3'd3, 3'd3, 3'd0);
        total++; if (sels() !== {3'd3, 3'd7, 15'd0}) begin bad++; $display("FAIL swap_same_ex1 got=%h exp=%h", sels(), {3'd3, 3'd7, 15'd0}); end
        @(negedge CLK);
        total++; if (strb() !== S_MOV_MID) begin bad++; $display("FAIL swap_same_ex2_strb got=%b exp=%b", strb(), S_MOV_MID); end
        @(negedge CLK);
        total++; if (sels() !== {3'd7, 3'd3, 15'd0}) begin bad++; $display("FAIL swap_same_ex3 got=%h exp=%h", sels(), {3'd7, 3'd3, 15'd0}); end
        total++; if (DONE !== 1'b1) begin bad++; $display("FAIL swap_same_done got=%b exp=1", DONE); end
    endtask

    task automatic test_errors();
        send_cmd(3'd3, 3'd1, 3'd7, 3'd0);
        total++; if (strb() !== S_ERR) begin bad++; $display("FAIL swap_src_tmp got=%b exp=%b", strb(), S_ERR); end
        total++; if (sels() !== 21'd0) begin bad++; $display("FAIL swap_src_tmp_sels got=%h exp=0", sels()); end
        @(negedge CLK);
        total++; if (strb() !== S_IDLE) begin bad++; $display("FAIL swap_err_after got=%b exp=%b", strb(), S_IDLE); end
        send_cmd(3'd3, 3'd7, 3'd0, 3'd0);
        total++; if (strb() !== S_ERR) begin bad++; $display("FAIL swap_dst_tmp got=%b exp=%b", strb(), S_ERR); end
        send_cmd(3'd5, 3'd2, 3'd0, 3'd0);
        total++; if (strb() !== S_AINC) begin bad++; $display("FAIL ainc_strb got=%b exp=%b", strb(), S_AINC); end
        total++; if (sels() !== {18'd0, 3'd2}) begin bad++; $display("FAIL ainc_sels got=%h exp=%h", sels(), {18'd0, 3'd2}); end
        @(negedge CLK);
        total++; if (ADDR_INC !== 1'b0) begin bad++; $display("FAIL ainc_one_cycle got=%b exp=0", ADDR_INC); end
        send_cmd(3'd6, 3'd2, 3'd1, 3'd4);
        total++; if (strb() !== S_ERR) begin bad++; $display("FAIL op6 got=%b exp=%b", strb(), S_ERR); end
        total++; if (sels() !== 21'd0) begin bad++; $display("FAIL op6_sels got=%h exp=0", sels()); end
        send_cmd(3'd7, 3'd3, 3'd1, 3'd0);
        total++; if (strb() !== S_ERR) begin bad++; $display("FAIL op7 got=%b exp=%b", strb(), S_ERR); end
        send_cmd(3'd4, 3'd6, 3'd3, 3'd0);
        total++; if (strb() !== S_AMOV) begin bad++; $display("FAIL amov_strb got=%b exp=%b", strb(), S_AMOV); end
        total++; if (sels() !== {12'd0, 3'd3, 3'd6, 3'd0}) begin bad++; $display("FAIL amov_sels got=%h exp=%h", sels(), {12'd0, 3'd3, 3'd6, 3'd0}); end
        send_cmd(3'd0, 3'd5, 3'd5, 3'd5);
        total++; if (strb() !== S_NOP) begin bad++; $display("FAIL nop_strb got=%b exp=%b", strb(), S_NOP); end
        total++; if (sels() !== 21'd0) begin bad++; $display("FAIL nop_sels got=%h exp=0", sels()); end
    endtask

    task automatic test_reset_mid_swap();
        send_cmd(3'd3, 3'd1, 3'd0, 3'd0);
        @(negedge CLK);
        total++; if (sels() !== {3'd1, 3'd0, 15'd0}) begin bad++; $display("FAIL rst_swap_ex2 got=%h exp=%h", sels(), {3'd1, 3'd0, 15'd0}); end
        RST = 1'b1;
        #1;
        total++; if (strb() !== S_IDLE) begin bad++; $display("FAIL rst_async_strb got=%b exp=%b", strb(), S_IDLE); end
        total++; if (sels() !== 21'd0) begin bad++; $display("FAIL rst_async_sels got=%h exp=0", sels()); end
        @(negedge CLK);
        RST = 1'b0;
        total++; if (CMD_READY !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", CMD_READY); end
        @(negedge CLK);
        total++; if (strb() !== S_IDLE) begin bad++; $display("FAIL rst_no_done got=%b exp=%b", strb(), S_IDLE); end
    endtask

    task automatic test_back_to_back();
        @(negedge CLK);
        CMD_VALID = 1'b1; CMD_OP = 3'd1; CMD_SRC = 3'd1; CMD_DST = 3'd3; CMD_SRC2 = 3'd0;
        @(negedge CLK);
        total++; if (sels() !== {3'd1, 3'd3, 15'd0}) begin bad++; $display("FAIL b2b_a_sels got=%h exp=%h", sels(), {3'd1, 3'd3, 15'd0}); end
        CMD_SRC = 3'd4; CMD_DST = 3'd6;
`ifdef REGFILE_CTRL_SKID_EN
        total++; if (CMD_READY !== 1'b1) begin bad++; $display("FAIL b2b_ready_a got=%b exp=1", CMD_READY); end
        @(negedge CLK);
        total++; if (strb() !== S_MOV_DONE) begin bad++; $display("FAIL b2b_b_strb got=%b exp=%b", strb(), S_MOV_DONE); end
        total++; if (sels() !== {3'd4, 3'd6, 15'd0}) begin bad++; $display("FAIL b2b_b_sels got=%h exp=%h", sels(), {3'd4, 3'd6, 15'd0}); end
        CMD_OP = 3'd5; CMD_DST = 3'd2;
        @(negedge CLK);
        CMD_VALID = 1'b0;
        total++; if (strb() !== S_AINC) begin bad++; $display("FAIL b2b_c_strb got=%b exp=%b", strb(), S_AINC); end
        total++; if (ADDR_INC_SEL !== 3'd2) begin bad++; $display("FAIL b2b_c_sel got=%0d exp=2", ADDR_INC_SEL); end
        @(negedge CLK);
        CMD_VALID = 1'b1; CMD_OP = 3'd3; CMD_SRC = 3'd0; CMD_DST = 3'd1;
        @(negedge CLK);
        total++; if (CMD_READY !== 1'b1) begin bad++; $display("FAIL skid_ready_ex1 got=%b exp=1", CMD_READY); end
        CMD_OP = 3'd1; CMD_SRC = 3'd2; CMD_DST = 3'd5;
        @(negedge CLK);
        CMD_VALID = 1'b0;
        total++; if (CMD_READY !== 1'b0) begin bad++; $display("FAIL skid_full_ready got=%b exp=0", CMD_READY); end
        total++; if (sels() !== {3'd1, 3'd0, 15'd0}) begin bad++; $display("FAIL skid_swap_ex2 got=%h exp=%h", sels(), {3'd1, 3'd0, 15'd0}); end
        @(negedge CLK);
        total++; if (CMD_READY !== 1'b0) begin bad++; $display("FAIL skid_full_ex3 got=%b exp=0", CMD_READY); end
        total++; if (DONE !== 1'b1) begin bad++; $display("FAIL skid_swap_done got=%b exp=1", DONE); end
        @(negedge CLK);
        total++; if (strb() !== S_MOV_DONE) begin bad++; $display("FAIL skid_pop_strb got=%b exp=%b", strb(), S_MOV_DONE); end
        total++; if (sels() !== {3'd2, 3'd5, 15'd0}) begin bad++; $display("FAIL skid_pop_sels got=%h exp=%h", sels(), {3'd2, 3'd5, 15'd0}); end
        total++; if (CMD_READY !== 1'b1) begin bad++; $display("FAIL skid_ready_back got=%b exp=1", CMD_READY); end
`else
        total++; if (CMD_READY !== 1'b0) begin bad++; $display("FAIL b2b_ready_a got=%b exp=0", CMD_READY); end
        @(negedge CLK);
        total++; if (strb() !== S_IDLE) begin bad++; $display("FAIL b2b_gap got=%b exp=%b", strb(), S_IDLE); end
        total++; if (CMD_READY !== 1'b1) begin bad++; $display("FAIL b2b_ready_gap got=%b exp=1", CMD_READY); end
        @(negedge CLK);
        CMD_VALID = 1'b0;
        total++; if (strb() !== S_MOV_DONE) begin bad++; $display("FAIL b2b_b_strb got=%b exp=%b", strb(), S_MOV_DONE); end
        total++; if (sels() !== {3'd4, 3'd6, 15'd0}) begin bad++; $display("FAIL b2b_b_sels got=%h exp=%h", sels(), {3'd4, 3'd6, 15'd0}); end
`endif
        @(negedge CLK);
        total++; if (strb() !== S_IDLE) begin bad++; $display("FAIL b2b_end got=%b exp=%b", strb(), S_IDLE); end
    endtask

    initial begin
        test_reset();
        test_mov();
        test_alu();
        test_swap();
        test_errors();
        test_reset_mid_swap();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_ctrl.md
Name: regfile_ctrl

Overview:
- Register-transfer sequencer that drives the control side of `registerfile`.
- Accepts one transfer command per valid/ready handshake.
- Expands each command into 1–3 cycles of active-low assert/load strobes and 3-bit selects.
- Sits between the instruction decoder and `registerfile`. Outputs connect 1:1 to the same-named `registerfile` inputs.

Parameters:
- TMP_REG, 7: main register index used as scratch by SWAP.
- SEL_W, 3: width of every register select.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- CMD_VALID  input  1  command present.
- CMD_READY  output  1  block can accept a command.
- CMD_OP  input  3  opcode: 0 NOP, 1 MOV, 2 ALU, 3 SWAP, 4 AMOV, 5 AINC, 6-7 illegal.
- CMD_DST  input  SEL_W  destination register.
- CMD_SRC  input  SEL_W  source / LHS register.
- CMD_SRC2  input  SEL_W  RHS register (ALU only).
- BUSY  output  1  command executing.
- DONE  output  1  high during final execution cycle of a command.
- CMD_ERR  output  1  high with DONE when the command was illegal.
- MAIN_ASSERT_bar, MAIN_LOAD_bar, LHS_ASSERT_bar, RHS_ASSERT_bar, ADDR_ASSERT_bar, ADDR_LOAD_bar  output  1 each  active-low strobes.
- ADDR_INC  output  1  active-high increment strobe.
- ALU_ASSERT_bar  output  1  ALU drives main bus.
- MAIN_ASSERT_SEL, MAIN_LOAD_SEL, LHS_ASSERT_SEL, RHS_ASSERT_SEL, ADDR_ASSERT_SEL, ADDR_LOAD_SEL, ADDR_INC_SEL  output  SEL_W each  register selects.

Behaviour:
- Reset (asynchronous, immediate):
  - State IDLE; latched command and buffer cleared.
  - All _bar strobes high; ADDR_INC, BUSY, DONE, CMD_ERR low; all selects 0; CMD_READY high after reset release.
- Reset mid-command aborts it: no DONE, no further strobes.
- Handshake:
  - Transfer on a rising edge with CMD_VALID & CMD_READY.
  - Command fields are latched on that edge. Input changes after it have no effect.
- FSM states: IDLE, EX1, EX2, EX3.
  - Accept moves IDLE→EX1.
  - Outputs are decoded from state + latched command (Moore), so no glitches.
  - BUSY = state != IDLE.
- Per-opcode cycles:
  - NOP: EX1 only; no strobes; DONE.
  - MOV: EX1: MAIN_ASSERT_SEL=SRC, MAIN_ASSERT_bar=0, MAIN_LOAD_SEL=DST, MAIN_LOAD_bar=0; DONE.
  - ALU:
    - EX1: LHS_ASSERT_SEL=SRC, RHS_ASSERT_SEL=SRC2, LHS/RHS_ASSERT_bar=0.
    - EX2: LHS/RHS strobes held; ALU_ASSERT_bar=0, MAIN_LOAD_SEL=DST, MAIN_LOAD_bar=0; DONE.
  - SWAP:
    - EX1: SRC→TMP_REG.
    - EX2: DST→SRC.
    - EX3: TMP_REG→DST; DONE.
    - Each step uses MOV-style strobes.
  - AMOV: EX1: ADDR_ASSERT_SEL=SRC, ADDR_ASSERT_bar=0, ADDR_LOAD_SEL=DST, ADDR_LOAD_bar=0; DONE.
  - AINC: EX1: ADDR_INC=1, ADDR_INC_SEL=DST; DONE.
- Errors execute as NOP (one cycle, DONE and CMD_ERR high):
  - opcodes 6-7;
  - SWAP with SRC or DST == TMP_REG.
- SWAP with SRC==DST is legal and runs all 3 cycles.
- Selects not used in a cycle are driven 0. ALU_ASSERT_bar and MAIN_ASSERT_bar are never low in the same cycle.
- After the DONE cycle: go to IDLE (see optional feature for back-to-back operation).
- Without the optional feature, CMD_READY = (state==IDLE). Minimum spacing is therefore latency+1 cycles.

Optional Feature:
- Macro: REGFILE_CTRL_SKID_EN.
- Defined:
  - Adds a one-entry command buffer; CMD_READY = buffer empty, so the block can accept while BUSY.
  - Accept while IDLE bypasses the buffer into EX1.
  - Accept while busy fills the buffer.
  - On a DONE cycle:
    - buffer full → next command loads from the buffer straight into EX1, no IDLE gap;
    - buffer empty with a simultaneous accept → that command goes straight to EX1.
  - Reset clears the buffer.
- Undefined: no buffer; behaviour as above.

Decomposition:
- Package regfile_ctrl_pkg:
  - op enum (OP_NOP..OP_AINC);
  - state enum;
  - SEL_W constant;
  - packed cmd struct {op, dst, src, src2}.
- Sub-module regfile_ctrl_cmdbuf: the one-entry skid buffer, instantiated only under REGFILE_CTRL_SKID_EN.

Test Plan:
- Reset mid-SWAP in EX2 → all _bar strobes high immediately, no DONE, CMD_READY=1 after release.
- MOV src=2 dst=5 → one cycle with MAIN_ASSERT_SEL=2, MAIN_LOAD_SEL=5, both _bar=0, DONE=1; READY returns next cycle.
- ALU src=1 src2=3 dst=4 → EX1 LHS_SEL=1, RHS_SEL=3; EX2 ALU_ASSERT_bar=0, MAIN_LOAD_SEL=4, DONE.
- SWAP 0,1 → three cycles 0→7, 1→0, 7→1. SWAP 7,1 → single cycle DONE+CMD_ERR, no strobes.
- AINC dst=2 then opcode 6 → ADDR_INC=1 with sel 2 for one cycle; then CMD_ERR pulse.
- With REGFILE_CTRL_SKID_EN, CMD_VALID held for MOV, MOV, AINC → commands execute on consecutive cycles, BUSY continuous, READY drops while the buffer is full.
